cypher_lock_ctrl: RTL and testbench

- Sequencing controller for the cypher lock.
- Collects three decimal key digits, compares them with a stored password, and opens, fails or locks out accordingly.
- Drives the 12-bit entered_password and 4-bit suffix consumed by the 8-digit scanning display driver.
- Supports changing the password while the lock is open.

---
 rtl/cypher_lock_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_cypher_lock_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cypher_lock_ctrl.sv
// cypher_lock_ctrl: sequencing controller for the cypher lock.
// Collects three decimal key digits, compares them with the stored password,
// and then opens, fails or locks out for a fixed number of clocks. While the
// lock is open, the password can be changed.
//
// Ports:
//   clk, rst          - system clock; asynchronous active-high reset
//   digit_in          - key value (only 0..9 accepted)
//   digit_valid       - one-cycle pulse that qualifies digit_in
//   confirm           - one-cycle pulse: submit the entry
//   clear             - one-cycle pulse: discard the entry
//   set_pw            - one-cycle pulse: enter password-change mode (OPEN only)
//   entered_password  - three display nibbles (4'hE = blank), newest digit in [3:0]
//   suffix            - status code for the low display digits
//   unlock            - lock actuator, high in OPEN and SETPW
//   alarm             - high in LOCKED
module cypher_lock_ctrl #(
  parameter logic [11:0] DEFAULT_PW  = 12'h123,
  parameter int unsigned MAX_FAIL    = 3,
  parameter logic [31:0] OPEN_CYCLES = 32'd500000000,
  parameter logic [31:0] FAIL_CYCLES = 32'd100000000,
  parameter logic [31:0] LOCK_CYCLES = 32'd1000000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  digit_in,
  input  logic        digit_valid,
  input  logic        confirm,
  input  logic        clear,
  input  logic        set_pw,
  output logic [11:0] entered_password,
  output logic [3:0]  suffix,
  output logic        unlock,
  output logic        alarm
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ENTRY  = 3'd1,
    ST_CHECK  = 3'd2,
    ST_OPEN   = 3'd3,
    ST_FAIL   = 3'd4,
    ST_LOCKED = 3'd5,
    ST_SETPW  = 3'd6
  } state_t;

  localparam logic [11:0] BLANK_PW   = 12'hEEE;
  localparam logic [3:0]  MAX_FAIL_C = 4'(MAX_FAIL);

  state_t      state_r, state_nxt_s;
  logic [1:0]  count_r, count_nxt_s;
  logic [3:0]  fail_cnt_r, fail_nxt_s;
  logic [11:0] stored_pw_r, stored_nxt_s;
  logic [11:0] pw_nxt_s;
  logic [31:0] timer_r, timer_nxt_s;
  logic [31:0] timer_last_s;
  logic [3:0]  fail_inc_s;
  logic        digit_ok_s;
  logic [3:0]  suffix_nxt_s;
  logic        unlock_nxt_s;
  logic        alarm_nxt_s;

  assign digit_ok_s = digit_valid && (digit_in <= 4'd9) && (count_r < 2'd3);
  assign fail_inc_s = fail_cnt_r + 4'd1;

  // Terminal timer value for the current timed state (state lasts N cycles).
  always_comb begin
    timer_last_s = 32'd0;
    case (state_r)
      ST_OPEN:   timer_last_s = OPEN_CYCLES - 32'd1;
      ST_FAIL:   timer_last_s = FAIL_CYCLES - 32'd1;
      ST_LOCKED: timer_last_s = LOCK_CYCLES - 32'd1;
      default:   timer_last_s = 32'd0;
    endcase
  end

  // State and datapath registers, including the registered Moore outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r          <= ST_IDLE;
      entered_password <= BLANK_PW;
      count_r          <= 2'd0;
      fail_cnt_r       <= 4'd0;
      stored_pw_r      <= DEFAULT_PW;
      timer_r          <= 32'd0;
      suffix           <= 4'h0;
      unlock           <= 1'b0;
      alarm            <= 1'b0;
    end else begin
      state_r          <= state_nxt_s;
      entered_password <= pw_nxt_s;
      count_r          <= count_nxt_s;
      fail_cnt_r       <= fail_nxt_s;
      stored_pw_r      <= stored_nxt_s;
      timer_r          <= timer_nxt_s;
      suffix           <= suffix_nxt_s;
      unlock           <= unlock_nxt_s;
      alarm            <= alarm_nxt_s;
    end
  end

  // Next-state and datapath update. Input priority is clear > confirm > digit;
  // the timer defaults to 0 so every timed state starts counting from zero.
  always_comb begin
    state_nxt_s  = state_r;
    pw_nxt_s     = entered_password;
    count_nxt_s  = count_r;
    fail_nxt_s   = fail_cnt_r;
    stored_nxt_s = stored_pw_r;
    timer_nxt_s  = 32'd0;
    case (state_r)
      ST_IDLE, ST_ENTRY: begin
        if (clear) begin
          pw_nxt_s    = BLANK_PW;
          count_nxt_s = 2'd0;
          state_nxt_s = ST_IDLE;
        end else if (confirm) begin
          if ((state_r == ST_ENTRY) && (count_r == 2'd3)) begin
            state_nxt_s = ST_CHECK;
          end else begin
            state_nxt_s = state_r;
          end
        end else if (digit_ok_s) begin
          pw_nxt_s    = {entered_password[7:0], digit_in};
          count_nxt_s = count_r + 2'd1;
          state_nxt_s = ST_ENTRY;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_CHECK: begin
        if (entered_password == stored_pw_r) begin
          state_nxt_s = ST_OPEN;
          fail_nxt_s  = 4'd0;
        end else if (fail_inc_s == MAX_FAIL_C) begin
          state_nxt_s = ST_LOCKED;
          fail_nxt_s  = fail_inc_s;
        end else begin
          state_nxt_s = ST_FAIL;
          fail_nxt_s  = fail_inc_s;
        end
      end
      ST_OPEN, ST_FAIL, ST_LOCKED: begin
        // set_pw only matters in OPEN and wins over the timeout.
        if ((state_r == ST_OPEN) && set_pw) begin
          state_nxt_s = ST_SETPW;
          pw_nxt_s    = BLANK_PW;
          count_nxt_s = 2'd0;
        end else if (timer_r == timer_last_s) begin
          state_nxt_s = ST_IDLE;
          pw_nxt_s    = BLANK_PW;
          count_nxt_s = 2'd0;
          if (state_r == ST_LOCKED) begin
            fail_nxt_s = 4'd0;
          end else begin
            fail_nxt_s = fail_cnt_r;
          end
        end else begin
          timer_nxt_s = timer_r + 32'd1;
        end
      end
      ST_SETPW: begin
        if (clear) begin
          pw_nxt_s    = BLANK_PW;
          count_nxt_s = 2'd0;
        end else if (confirm) begin
          if (count_r == 2'd3) begin
            stored_nxt_s = entered_password;
            state_nxt_s  = ST_IDLE;
            pw_nxt_s     = BLANK_PW;
            count_nxt_s  = 2'd0;
          end else begin
            state_nxt_s = ST_SETPW;
          end
        end else if (digit_ok_s) begin
          pw_nxt_s    = {entered_password[7:0], digit_in};
          count_nxt_s = count_r + 2'd1;
        end else begin
          state_nxt_s = ST_SETPW;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        pw_nxt_s    = BLANK_PW;
        count_nxt_s = 2'd0;
      end
    endcase
  end

  // Output values for the upcoming state; CHECK keeps the previous suffix.
  always_comb begin
    suffix_nxt_s = suffix;
    unlock_nxt_s = 1'b0;
    alarm_nxt_s  = 1'b0;
    case (state_nxt_s)
      ST_IDLE:   suffix_nxt_s = 4'h0;
      ST_ENTRY:  suffix_nxt_s = {2'b00, count_nxt_s};
      ST_CHECK:  suffix_nxt_s = suffix;
      ST_OPEN: begin
        suffix_nxt_s = 4'h8;
        unlock_nxt_s = 1'b1;
      end
      ST_FAIL:   suffix_nxt_s = fail_nxt_s;
      ST_LOCKED: begin
        suffix_nxt_s = 4'hF;
        alarm_nxt_s  = 1'b1;
      end
      ST_SETPW: begin
        suffix_nxt_s = {2'b00, count_nxt_s};
        unlock_nxt_s = 1'b1;
      end
      default:   suffix_nxt_s = 4'h0;
    endcase
  end

endmodule

// File: tb/tb_cypher_lock_ctrl.sv
// Scoreboard bench for cypher_lock_ctrl: the stimulus process steps a
// digit-queue reference model and queues the expected outputs; a monitor
// process compares them one cycle later.
module tb_cypher_lock_ctrl;

  localparam int OPEN_N = 4;
  localparam int FAIL_N = 3;
  localparam int LOCK_N = 5;
  localparam int MAXF   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  digit_in = 4'd0;
  logic        digit_valid = 1'b0;
  logic        confirm = 1'b0;
  logic        clear = 1'b0;
  logic        set_pw = 1'b0;
  logic [11:0] entered_password;
  logic [3:0]  suffix;
  logic        unlock;
  logic        alarm;

  int checks = 0;
  int errors = 0;

  cypher_lock_ctrl #(
    .DEFAULT_PW (12'h123),
    .MAX_FAIL   (MAXF),
    .OPEN_CYCLES(32'd4),
    .FAIL_CYCLES(32'd3),
    .LOCK_CYCLES(32'd5)
  ) dut (
    .clk(clk), .rst(rst), .digit_in(digit_in), .digit_valid(digit_valid),
    .confirm(confirm), .clear(clear), .set_pw(set_pw),
    .entered_password(entered_password), .suffix(suffix),
    .unlock(unlock), .alarm(alarm)
  );

  always #5 clk = ~clk;

  // Reference model: entry held as a queue of digits, password as three digits,
  // timed modes as a countdown of remaining cycles.
  typedef enum {M_IDLE, M_ENTRY, M_CHECK, M_OPEN, M_FAIL, M_LOCK, M_SET} mode_e;
  mode_e m_mode;
  int    m_digits[$];
  int    m_pw[3];
  int    m_fails;
  int    m_remain;
  int    m_suffix;

  logic [17:0] exp_q[$];

  function automatic void model_reset();
    m_mode = M_IDLE;
    m_digits.delete();
    m_pw[0] = 1; m_pw[1] = 2; m_pw[2] = 3;
    m_fails = 0; m_remain = 0; m_suffix = 0;
  endfunction

  function automatic void model_step(bit dv, int d, bit cf, bit cl, bit sp);
    bit accept;
    accept = dv && (d <= 9) && (m_digits.size() < 3);
    case (m_mode)
      M_IDLE, M_ENTRY, M_SET: begin
        if (cl) begin
          m_digits.delete();
          if (m_mode == M_ENTRY) m_mode = M_IDLE;
        end else if (cf) begin
          if (m_digits.size() == 3 && m_mode == M_ENTRY) begin
            m_mode = M_CHECK;
          end else if (m_digits.size() == 3 && m_mode == M_SET) begin
            for (int i = 0; i < 3; i++) m_pw[i] = m_digits[i];
            m_digits.delete();
            m_mode = M_IDLE;
          end
        end else if (accept) begin
          m_digits.push_back(d);
          if (m_mode == M_IDLE) m_mode = M_ENTRY;
        end
      end
      M_CHECK: begin
        if (m_digits[0] == m_pw[0] && m_digits[1] == m_pw[1] && m_digits[2] == m_pw[2]) begin
          m_mode = M_OPEN; m_remain = OPEN_N; m_fails = 0;
        end else begin
          m_fails++;
          if (m_fails == MAXF) begin m_mode = M_LOCK; m_remain = LOCK_N; end
          else begin m_mode = M_FAIL; m_remain = FAIL_N; end
        end
      end
      M_OPEN, M_FAIL, M_LOCK: begin
        if (m_mode == M_OPEN && sp) begin
          m_mode = M_SET;
          m_digits.delete();
        end else begin
          m_remain--;
          if (m_remain == 0) begin
            if (m_mode == M_LOCK) m_fails = 0;
            m_mode = M_IDLE;
            m_digits.delete();
          end
        end
      end
      default: m_mode = M_IDLE;
    endcase
    case (m_mode)
      M_IDLE:          m_suffix = 0;
      M_ENTRY, M_SET:  m_suffix = m_digits.size();
      M_OPEN:          m_suffix = 8;
      M_FAIL:          m_suffix = m_fails;
      M_LOCK:          m_suffix = 15;
      default:         m_suffix = m_suffix;
    endcase
  endfunction

  function automatic logic [11:0] model_disp();
    logic [11:0] v;
    v = 12'hEEE;
    foreach (m_digits[i]) v = {v[7:0], 4'(m_digits[i])};
    return v;
  endfunction

  function automatic logic [17:0] model_outputs();
    logic u, a;
    u = (m_mode == M_OPEN) || (m_mode == M_SET);
    a = (m_mode == M_LOCK);
    return {model_disp(), 4'(m_suffix), u, a};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(logic dv, logic [3:0] d, logic cf, logic cl, logic sp);
    @(negedge clk);
    digit_valid = dv; digit_in = d; confirm = cf; clear = cl; set_pw = sp;
    model_step(dv, int'(d), cf, cl, sp);
    exp_q.push_back(model_outputs());
    @(posedge clk);
    #1;
    digit_valid = 1'b0; confirm = 1'b0; clear = 1'b0; set_pw = 1'b0;
  endtask

  task automatic dig(logic [3:0] d);  step(1'b1, d, 1'b0, 1'b0, 1'b0); endtask
  task automatic conf();              step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0); endtask
  task automatic clr();               step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0); endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic code(logic [3:0] a, logic [3:0] b, logic [3:0] c);
    dig(a); dig(b); dig(c); conf();
  endtask

  // Monitor: one expected output word per clock after each stimulus edge.
  initial begin : monitor
    logic [17:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({entered_password, suffix, unlock, alarm} !== e) begin
          errors++;
          $display("FAIL scoreboard t=%0t: pw=%h suffix=%h unlock=%b alarm=%b expected pw=%h suffix=%h unlock=%b alarm=%b",
                   $time, entered_password, suffix, unlock, alarm, e[17:6], e[5:2], e[1], e[0]);
        end
      end
    end
  end

  initial begin : stimulus
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_pw", 32'(entered_password), 32'h0EEE);
    check("reset_suffix", 32'(suffix), 32'h0);
    check("reset_unlock", 32'(unlock), 32'h0);
    check("reset_alarm", 32'(alarm), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Correct code opens for OPEN_N cycles.
    code(4'd1, 4'd2, 4'd3);
    idle(7);

    // Three wrong codes: FAIL, FAIL, then LOCKED with ignored digits.
    code(4'd4, 4'd5, 4'd6); idle(5);
    code(4'd4, 4'd5, 4'd6); idle(5);
    code(4'd4, 4'd5, 4'd6); idle(1);
    dig(4'd7); dig(4'd8); conf(); clr();
    idle(4);

    // Entry edge cases.
    dig(4'hB);
    dig(4'd7); dig(4'd8); dig(4'd9); dig(4'd1);
    clr();
    dig(4'd1); dig(4'd2); conf(); dig(4'd3);
    step(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    idle(2);

    // Password change, then old code fails and new code opens.
    code(4'd1, 4'd2, 4'd3); idle(1);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    dig(4'd9); dig(4'd0); conf(); dig(4'd7); conf();
    idle(1);
    code(4'd1, 4'd2, 4'd3); idle(5);
    code(4'd9, 4'd0, 4'd7); idle(2);

    // Asynchronous reset while open.
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_unlock", 32'(unlock), 32'h0);
    check("async_rst_pw", 32'(entered_password), 32'h0EEE);
    check("async_rst_suffix", 32'(suffix), 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    code(4'd1, 4'd2, 4'd3);
    idle(7);

    // Randomized traffic biased toward the stored password.
    for (int i = 0; i < 800; i++) begin
      int r;
      logic [3:0] d;
      r = $urandom_range(0, 11);
      if ($urandom_range(0, 2) != 0) d = 4'(m_pw[m_digits.size() % 3]);
      else d = 4'($urandom_range(0, 15));
      case (r)
        0, 1, 2, 3, 4: dig(d);
        5, 6:          conf();
        7:             clr();
        8:             step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        default:       idle(1);
      endcase
    end
    idle(12);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
